// File: rtl/idex_stage_register_if.sv
// ID/EX stage bundle: decode-side inputs, pipeline control and the
// registered EX-side outputs of the ID/EX boundary register.
//   master : upstream driver (ID stage / hazard-control source)
//   slave  : the idex_stage_register itself
// Signals:
//   id_instr, id_ctrl, id_rs_data, id_rt_data, id_pc : ID-stage contents
//   flush, hold                                      : squash / freeze requests
//   ex_ctrl, ex_instr, ex_rs_data, ex_rt_data, ex_pc8,
//   ex_dest_addr, ex_valid                           : registered EX view
//   stall_out                                        : upstream stall (comb)
//   hazard_count                                     : saturating bubble count
interface idex_stage_register_if #(
    parameter int unsigned HAZ_CNT_W = 16
);
    logic [31:0]          id_instr;
    logic [23:0]          id_ctrl;
    logic [31:0]          id_rs_data;
    logic [31:0]          id_rt_data;
    logic [31:0]          id_pc;
    logic                 flush;
    logic                 hold;
    logic [23:0]          ex_ctrl;
    logic [31:0]          ex_instr;
    logic [31:0]          ex_rs_data;
    logic [31:0]          ex_rt_data;
    logic [31:0]          ex_pc8;
    logic [4:0]           ex_dest_addr;
    logic                 ex_valid;
    logic                 stall_out;
    logic [HAZ_CNT_W-1:0] hazard_count;

    modport master (
        output id_instr, id_ctrl, id_rs_data, id_rt_data, id_pc, flush, hold,
        input  ex_ctrl, ex_instr, ex_rs_data, ex_rt_data, ex_pc8,
               ex_dest_addr, ex_valid, stall_out, hazard_count
    );

    modport slave (
        input  id_instr, id_ctrl, id_rs_data, id_rt_data, id_pc, flush, hold,
        output ex_ctrl, ex_instr, ex_rs_data, ex_rt_data, ex_pc8,
               ex_dest_addr, ex_valid, stall_out, hazard_count
    );
endinterface

// File: rtl/idex_stage_register.sv
// ID/EX pipeline boundary register of the PPU pipeline.
// Captures the control bundle and decode operands, resolves the destination
// register, detects load-use hazards against EX and inserts a one-cycle
// bubble while stalling upstream. Flush squashes, hold freezes.
// Ports:
//   clk   : pipeline clock (rising edge)
//   reset : asynchronous active-high reset
//   bus   : idex_stage_register_if.slave (ID inputs, flush/hold, EX outputs,
//           stall_out, hazard_count)
module idex_stage_register #(
    parameter int unsigned HAZ_CNT_W = 16
) (
    input  logic                   clk,
    input  logic                   reset,
    idex_stage_register_if.slave   bus
);
    typedef enum logic {
        EMPTY = 1'b0,
        VALID = 1'b1
    } state_t;

    state_t               state_q;
    logic [23:0]          ctrl_q;
    logic [31:0]          instr_q;
    logic [31:0]          rs_data_q;
    logic [31:0]          rt_data_q;
    logic [31:0]          pc8_q;
    logic [4:0]           dest_q;
    logic [HAZ_CNT_W-1:0] haz_cnt_q;

    logic [4:0] dest_resolved;
    logic       ex_valid;
    logic       ex_load;
    logic       hazard;

    assign ex_valid = (state_q == VALID);

    always_comb begin
        dest_resolved = '0;
        unique case (bus.id_ctrl[19:18])
            2'b00: dest_resolved = '0;
            2'b01: dest_resolved = bus.id_instr[15:11];
            2'b10: dest_resolved = bus.id_instr[20:16];
            2'b11: dest_resolved = 5'd31;
        endcase
    end

    // Load_Instr alone is not enough: ADDIU also raises it, so MEM_Enable
    // must be set too for a real memory load.
    assign ex_load = ex_valid & ctrl_q[9] & ctrl_q[2];

    // rs/rt compare applied regardless of format (conservative).
    assign hazard = ex_load && (dest_q != 5'd0) && (bus.id_instr != 32'd0) &&
                    ((bus.id_instr[25:21] == dest_q) ||
                     (bus.id_instr[20:16] == dest_q));

    // Reset forces ex_valid low, so only hold needs explicit masking here.
    assign bus.stall_out = (hazard | bus.hold) & ~bus.flush & ~reset;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= EMPTY;
            ctrl_q    <= '0;
            instr_q   <= '0;
            rs_data_q <= '0;
            rt_data_q <= '0;
            pc8_q     <= '0;
            dest_q    <= '0;
            haz_cnt_q <= '0;
        end else if (bus.flush || (!bus.hold && hazard)) begin
            state_q   <= EMPTY;
            ctrl_q    <= '0;
            instr_q   <= '0;
            rs_data_q <= '0;
            rt_data_q <= '0;
            pc8_q     <= '0;
            dest_q    <= '0;
            // Only hazard bubbles are counted, never flush bubbles.
            if (!bus.flush && (haz_cnt_q != '1)) begin
                haz_cnt_q <= haz_cnt_q + 1'b1;
            end
        end else if (!bus.hold) begin
            state_q   <= (bus.id_instr != 32'd0) ? VALID : EMPTY;
            ctrl_q    <= bus.id_ctrl;
            instr_q   <= bus.id_instr;
            rs_data_q <= bus.id_rs_data;
            rt_data_q <= bus.id_rt_data;
            pc8_q     <= bus.id_pc + 32'd8;
            dest_q    <= dest_resolved;
        end
    end

    assign bus.ex_ctrl      = ctrl_q;
    assign bus.ex_instr     = instr_q;
    assign bus.ex_rs_data   = rs_data_q;
    assign bus.ex_rt_data   = rt_data_q;
    assign bus.ex_pc8       = pc8_q;
    assign bus.ex_dest_addr = dest_q;
    assign bus.ex_valid     = ex_valid;
    assign bus.hazard_count = haz_cnt_q;
endmodule

// File: tb/tb_idex_stage_register.sv
// Directed self-checking bench for idex_stage_register.
module tb_idex_stage_register;
    logic clk;
    logic reset;
    int   checks;
    int   failures;

    idex_stage_register_if #(.HAZ_CNT_W(16)) bus ();

    idex_stage_register #(.HAZ_CNT_W(16)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic [31:0] instr, input logic [23:0] ctrl,
                         input logic [31:0] rs, input logic [31:0] rt,
                         input logic [31:0] pc);
        bus.id_instr   = instr;
        bus.id_ctrl    = ctrl;
        bus.id_rs_data = rs;
        bus.id_rt_data = rt;
        bus.id_pc      = pc;
        #1;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    localparam logic [31:0] ADDIU = 32'h24050007;
    localparam logic [23:0] ADDIU_C = 24'h0A0300;
    localparam logic [31:0] LBU = 32'h90250000;
    localparam logic [23:0] LBU_C = 24'h080304;
    localparam logic [31:0] ADDU = 32'h00A23021;
    localparam logic [23:0] ADDU_C = 24'h040100;

    initial begin
        checks = 0;
        failures = 0;
        reset = 1'b1;
        bus.flush = 1'b0;
        bus.hold  = 1'b0;
        drive('0, '0, '0, '0, '0);
        #2;
        chk("rst_valid", {31'd0, bus.ex_valid}, 32'd0);
        chk("rst_ctrl", {8'd0, bus.ex_ctrl}, 32'd0);
        chk("rst_cnt", {16'd0, bus.hazard_count}, 32'd0);
        step();
        reset = 1'b0;

        // Plain capture; ADDIU has Load_Instr but no MEM_Enable.
        drive(ADDIU, ADDIU_C, 32'h11111111, 32'h22222222, 32'h100);
        step();
        chk("cap_ctrl", {8'd0, bus.ex_ctrl}, 32'h000A0300);
        chk("cap_dest", {27'd0, bus.ex_dest_addr}, 32'd5);
        chk("cap_pc8", bus.ex_pc8, 32'h108);
        chk("cap_valid", {31'd0, bus.ex_valid}, 32'd1);
        chk("cap_rs", bus.ex_rs_data, 32'h11111111);
        chk("cap_rt", bus.ex_rt_data, 32'h22222222);
        drive(ADDU, ADDU_C, '0, '0, 32'h104);
        chk("addiu_nohaz", {31'd0, bus.stall_out}, 32'd0);

        // Load-use hazard.
        drive(LBU, LBU_C, 32'h0, 32'h0, 32'h104);
        step();
        chk("lbu_dest", {27'd0, bus.ex_dest_addr}, 32'd5);
        drive(ADDU, ADDU_C, 32'hAAAA0000, 32'h0000BBBB, 32'h108);
        chk("lu_stall", {31'd0, bus.stall_out}, 32'd1);
        step();
        chk("lu_bub_valid", {31'd0, bus.ex_valid}, 32'd0);
        chk("lu_bub_ctrl", {8'd0, bus.ex_ctrl}, 32'd0);
        chk("lu_bub_instr", bus.ex_instr, 32'd0);
        chk("lu_bub_pc8", bus.ex_pc8, 32'd0);
        chk("lu_cnt", {16'd0, bus.hazard_count}, 32'd1);
        chk("lu_stall_clr", {31'd0, bus.stall_out}, 32'd0);
        step();
        chk("lu_retry_dest", {27'd0, bus.ex_dest_addr}, 32'd6);
        chk("lu_retry_instr", bus.ex_instr, ADDU);
        chk("lu_retry_pc8", bus.ex_pc8, 32'h110);
        chk("lu_retry_valid", {31'd0, bus.ex_valid}, 32'd1);

        // Flush over hazard.
        drive(LBU, LBU_C, '0, '0, 32'h200);
        step();
        drive(ADDU, ADDU_C, '0, '0, 32'h204);
        bus.flush = 1'b1;
        #1;
        chk("fl_stall", {31'd0, bus.stall_out}, 32'd0);
        step();
        bus.flush = 1'b0;
        chk("fl_valid", {31'd0, bus.ex_valid}, 32'd0);
        chk("fl_instr", bus.ex_instr, 32'd0);
        chk("fl_cnt", {16'd0, bus.hazard_count}, 32'd1);

        // JAL with PC wrap-around.
        drive(32'h0C000040, 24'h3C0100, '0, '0, 32'hFFFFFFFC);
        step();
        chk("jal_dest", {27'd0, bus.ex_dest_addr}, 32'd31);
        chk("jal_pc8", bus.ex_pc8, 32'h00000004);

        // Destination select 00 resolves to r0.
        drive(32'hAC250010, 24'h000014, '0, '0, 32'h300);
        step();
        chk("d00_dest", {27'd0, bus.ex_dest_addr}, 32'd0);
        chk("d00_valid", {31'd0, bus.ex_valid}, 32'd1);

        // NOP capture empties EX.
        drive('0, '0, '0, '0, 32'h304);
        step();
        chk("nop_valid", {31'd0, bus.ex_valid}, 32'd0);
        chk("nop_pc8", bus.ex_pc8, 32'h30C);

        // Hold for three cycles with changing ID inputs.
        drive(ADDU, ADDU_C, 32'h5, 32'h6, 32'h400);
        step();
        bus.hold = 1'b1;
        for (int i = 0; i < 3; i++) begin
            drive(32'h01000000 + i, 24'h040100, 32'h0 + i, '0, 32'h500 + 4 * i);
            chk("hold_stall", {31'd0, bus.stall_out}, 32'd1);
            step();
            chk("hold_instr", bus.ex_instr, ADDU);
            chk("hold_pc8", bus.ex_pc8, 32'h408);
            chk("hold_rs", bus.ex_rs_data, 32'h5);
        end
        bus.hold = 1'b0;
        drive(ADDIU, ADDIU_C, '0, '0, 32'h600);
        step();
        chk("hold_rel_instr", bus.ex_instr, ADDIU);
        chk("hold_rel_pc8", bus.ex_pc8, 32'h608);

        // Hold together with hazard: frozen, then bubble after release.
        drive(LBU, LBU_C, '0, '0, 32'h700);
        step();
        drive(ADDU, ADDU_C, '0, '0, 32'h704);
        bus.hold = 1'b1;
        #1;
        chk("hh_stall", {31'd0, bus.stall_out}, 32'd1);
        step();
        chk("hh_frozen", bus.ex_instr, LBU);
        chk("hh_cnt", {16'd0, bus.hazard_count}, 32'd1);
        bus.hold = 1'b0;
        #1;
        chk("hh_rel_stall", {31'd0, bus.stall_out}, 32'd1);
        step();
        chk("hh_bub_valid", {31'd0, bus.ex_valid}, 32'd0);
        chk("hh_cnt2", {16'd0, bus.hazard_count}, 32'd2);
        step();
        chk("hh_retry", bus.ex_instr, ADDU);

        // Asynchronous reset mid-cycle with ADDU in EX.
        bus.hold = 1'b1;
        #2;
        reset = 1'b1;
        #1;
        chk("ar_instr", bus.ex_instr, 32'd0);
        chk("ar_valid", {31'd0, bus.ex_valid}, 32'd0);
        chk("ar_dest", {27'd0, bus.ex_dest_addr}, 32'd0);
        chk("ar_cnt", {16'd0, bus.hazard_count}, 32'd0);
        chk("ar_stall", {31'd0, bus.stall_out}, 32'd0);
        bus.hold = 1'b0;
        step();
        reset = 1'b0;
        drive(ADDIU, ADDIU_C, '0, '0, 32'h800);
        step();
        chk("post_rst_cap", bus.ex_instr, ADDIU);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
